floating_point_divider: RTL
===========================

FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-004 SHALL have port reg_1, input, 32, IEEE-754 single-precision dividend.
REQ-005 SHALL have port reg_2, input, 32, IEEE-754 single-precision divisor.
REQ-006 SHALL have port result, output, 32, quotient, registered, held until next DONE.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, high for exactly one cycle (DONE state) per operation.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, DIVIDE, NORM, DONE; DONE always returns to IDLE next edge.
REQ-010 SHALL, on the edge sampling start=1 in IDLE (edge 0), capture reg_1/reg_2 and go to LOAD; start while busy is ignored, with no queuing.
REQ-011 SHALL in LOAD classify operands: exponent 0 means zero (denormals flushed, fraction ignored), exponent 255 with fraction 0 means inf, exponent 255 with fraction nonzero means NaN.
REQ-012 SHALL, for special cases, go LOAD->DONE at edge 1 (done high after edge 1), skipping DIVIDE/NORM.
REQ-013 SHALL use special results: any NaN, 0/0 or inf/inf gives 32'h7FC00000; nonzero/0 or inf/finite gives signed inf; finite/inf or 0/nonzero gives signed zero.
REQ-014 SHALL set sign = reg_1[31] XOR reg_2[31] for all non-NaN results.
REQ-015 SHALL, for normal operands, go LOAD->DIVIDE at edge 1 and run radix-2 restoring division of 1.fa by 1.fb, one quotient bit per cycle, 26 iterations (edges 2..27), then go to NORM.
REQ-016 SHALL compute biased exponent as ea - eb + 127 in signed 10-bit arithmetic; if quotient MSB is 0 (quotient < 1), shift left one and decrement exponent.
REQ-017 SHALL round to nearest-even using guard bit plus sticky (OR of remaining quotient bits and nonzero remainder); mantissa carry-out re-normalizes and increments exponent.
REQ-018 SHALL produce signed inf if final exponent >= 255, and signed zero if final exponent <= 0 (no subnormal output).
REQ-019 SHALL in NORM register result at edge 28 and enter DONE; done=1 during the cycle after edge 28, for a normal-path latency of 28 edges from start sampling to done.
REQ-020 SHALL leave result unchanged outside the DONE-entry edge.

Reset
REQ-021 SHALL, on reset_n low at any time including mid-DIVIDE, immediately force state IDLE, result 32'h0, busy 0, done 0, and clear the iteration counter and remainder.
REQ-022 SHALL, after reset_n deassertion, accept start on the first rising edge.

Structure
REQ-023 SHALL place the following in a shared package, shared with the multiplier: bias 127, exponent/mantissa widths, iteration count 26, QNaN 32'h7FC00000, inf/zero patterns, and the FSM state enum.
REQ-024 SHALL split into sub-module controller_div (FSM, 5-bit iteration counter, busy/done) and a divider datapath, mirroring the multiplier's controller/datapath split.

Verification
REQ-025 SHALL check that reg_1=40C00000 (6.0), reg_2=40000000 (2.0), start pulse gives result 40400000 with done high exactly one cycle after 28 edges and busy high throughout.
REQ-026 SHALL check that 3F800000 / 40400000 (1/3) gives 3EAAAAAB (round-to-nearest-even up).
REQ-027 SHALL check that 3F800000 / 00000000 gives 7F800000 with done after edge 1, and that 00000000 / 00000000 gives 7FC00000.
REQ-028 SHALL check that 7F7FFFFF / 00800000 gives 7F800000 (overflow), and that 00800000 / 7F7FFFFF gives 00000000 (underflow flush).
REQ-029 SHALL check that reset_n driven low at cycle 10 of DIVIDE gives busy 0, done 0, result 0 asynchronously, and that a new 6.0/2.0 op then completes correctly.
REQ-030 SHALL check that start pulsed while busy with different operands leaves the first op's result intact and produces a single done.

Source files
------------

// File: rtl/floating_point_divider_pkg.sv
// Shared floating-point constants and FSM state encoding for the divider/multiplier blocks.
package floating_point_divider_pkg;

  localparam int unsigned ExpWidth  = 8;
  localparam int unsigned MantWidth = 23;
  localparam int unsigned Bias      = 127;
  localparam int unsigned IterCount = 26;
  localparam int unsigned CntWidth  = 5;

  localparam logic [31:0] QNaN    = 32'h7FC0_0000;
  localparam logic [30:0] InfMag  = 31'h7F80_0000;
  localparam logic [30:0] ZeroMag = 31'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDivide,
    StNorm,
    StDone
  } state_e;

endpackage

// File: rtl/floating_point_divider_if.sv
// Request/response bundle between a requester and the floating-point divider.
interface floating_point_divider_if;
  logic        start;
  logic [31:0] reg_1;
  logic [31:0] reg_2;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, reg_1, reg_2,
    input  result, busy, done
  );

  modport slave (
    input  start, reg_1, reg_2,
    output result, busy, done
  );
endinterface

// File: rtl/controller_div.sv
// Sequencing FSM for the divider: IDLE -> LOAD -> (DIVIDE x26 -> NORM |) -> DONE -> IDLE.
module controller_div
  import floating_point_divider_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start_i,
  input  logic   special_i,
  output state_e state_o,
  output logic   busy_o,
  output logic   done_o
);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and iteration count; special operands bypass the divide loop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = special_i ? StDone : StDivide;
      end
      StDivide: begin
        if (cnt_q == CntWidth'(IterCount - 1)) begin
          cnt_d   = '0;
          state_d = StNorm;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNorm:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    state_o = state_q;
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StDone);
  end

endmodule

// File: rtl/floating_point_divider_datapath.sv
// Operand capture, special-case classification, restoring mantissa division and rounding.
module floating_point_divider_datapath
  import floating_point_divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  state_e      state_i,
  input  logic        start_i,
  input  logic [31:0] reg_1_i,
  input  logic [31:0] reg_2_i,
  output logic        special_o,
  output logic [31:0] result_o
);

  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [25:0]       quo_q, quo_d;
  logic signed [9:0] exp_q, exp_d;
  logic [31:0]       result_q, result_d;

  logic              sign;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [31:0]       special_res;
  logic signed [9:0] exp_init;

  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic              guard, sticky, round_up;
  logic signed [9:0] exp_n, exp_f;
  logic [22:0]       frac_f;
  logic [31:0]       norm_res;
  logic [24:0]       rem_sub;
  logic              rem_ge;

  // Operand classification; denormals are treated as zero.
  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_zero = (a_q[30:23] == 8'h00);
    a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
    a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
    b_zero = (b_q[30:23] == 8'h00);
    b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
    b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
    special_o = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = QNaN;
    end else if (a_inf || b_zero) begin
      special_res = {sign, InfMag};
    end else begin
      special_res = {sign, ZeroMag};
    end
    exp_init = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
             + $signed(10'(Bias));
  end

  // One restoring-division step: subtract when the partial remainder covers the divisor.
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
  end

  // Normalise the 26-bit quotient, round to nearest-even, then saturate/flush the exponent.
  always_comb begin
    if (quo_q[25]) begin
      mant   = quo_q[25:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_q;
    end else begin
      mant   = quo_q[24:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      exp_n  = exp_q - 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = mant_r[22:0];
      exp_f  = exp_n;
    end
    if (exp_f >= 10'sd255) begin
      norm_res = {sign, InfMag};
    end else if (exp_f <= 10'sd0) begin
      norm_res = {sign, ZeroMag};
    end else begin
      norm_res = {sign, exp_f[7:0], frac_f};
    end
  end

  // Per-state datapath register updates.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    result_d = result_q;
    unique case (state_i)
      StIdle: begin
        if (start_i) begin
          a_d = reg_1_i;
          b_d = reg_2_i;
        end
      end
      StLoad: begin
        if (special_o) begin
          result_d = special_res;
        end else begin
          rem_d = {2'b01, a_q[22:0]};
          div_d = {1'b1, b_q[22:0]};
          quo_d = '0;
          exp_d = exp_init;
        end
      end
      StDivide: begin
        quo_d = {quo_q[24:0], rem_ge};
        rem_d = {rem_sub[23:0], 1'b0};
      end
      StNorm:  result_d = norm_res;
      default: ;
    endcase
  end

  // Datapath state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/floating_point_divider.sv
// IEEE-754 single-precision divider top: controller plus datapath behind the bus interface.
module floating_point_divider
  import floating_point_divider_pkg::*;
(
  input logic                     clk,
  input logic                     reset_n,
  floating_point_divider_if.slave bus
);

  state_e      state;
  logic        special;
  logic        busy;
  logic        done;
  logic [31:0] result;

  controller_div u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (bus.start),
    .special_i (special),
    .state_o   (state),
    .busy_o    (busy),
    .done_o    (done)
  );

  floating_point_divider_datapath u_dp (
    .clk       (clk),
    .reset_n   (reset_n),
    .state_i   (state),
    .start_i   (bus.start),
    .reg_1_i   (bus.reg_1),
    .reg_2_i   (bus.reg_2),
    .special_o (special),
    .result_o  (result)
  );

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;

endmodule
